// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: fetch FSM states, reset PC and the
// bubble (NOP) instruction also used by the IF/ID register.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      FS_REQ   = 2'd0,
      FS_WAIT  = 2'd1,
      FS_VALID = 2'd2,
      FS_DROP  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] BUBBLE_INST = 32'h0000_0013;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection: redirect > predicted target > sequential pc+4.
// Ports: pc_i current PC, advance_i request accepted, bp_* predictor,
// redirect_* flush target, pc_next_o PC for the next cycle.
module if_next_pc (
   input  logic [31:0] pc_i,
   input  logic        advance_i,
   input  logic        bp_taken_i,
   input  logic [31:0] bp_target_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_next_o
);

   always_comb begin
      pc_next_o = pc_i;
      if (redirect_i) begin
         pc_next_o = redirect_pc_i;
      end else if (advance_i) begin
         pc_next_o = bp_taken_i ? bp_target_i : pc_i + 32'd4;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: single-outstanding IM reads, predictor
// steering and redirect flush. Ports: clk/rst, im_* IM req/gnt/rvalid
// port, bp_* predictor, redirect/redirect_pc from EX, stall/DM_stall
// holds, F_* and IM_stall toward the IF/ID register.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = if_fetch_unit_pkg::RESET_PC,
   parameter logic [31:0] BUBBLE_INST = if_fetch_unit_pkg::BUBBLE_INST
) (
   input  logic        clk,
   input  logic        rst,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_gnt,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   input  logic        bp_taken,
   input  logic [31:0] bp_target,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   input  logic        DM_stall,
   output logic [31:0] F_pc,
   output logic [31:0] F_inst,
   output logic        F_PredictTaken,
   output logic        IM_stall
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic         req_pred_q, req_pred_d;
   logic [31:0]  f_pc_q, f_pc_d;
   logic [31:0]  f_inst_q, f_inst_d;
   logic         f_pred_q, f_pred_d;
   logic         run_q;
   logic         gnt_fire;

   // run_q keeps im_req low for the cycle in which reset is released
   assign im_req         = run_q & (state_q == FS_REQ);
   assign im_addr        = pc_q;
   assign IM_stall       = (state_q != FS_VALID);
   assign F_pc           = f_pc_q;
   assign F_inst         = f_inst_q;
   assign F_PredictTaken = f_pred_q;
   assign gnt_fire       = im_req & im_gnt;

   if_next_pc u_next_pc (
      .pc_i          (pc_q),
      .advance_i     (gnt_fire),
      .bp_taken_i    (bp_taken),
      .bp_target_i   (bp_target),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .pc_next_o     (pc_d)
   );

   always_comb begin
      state_d    = state_q;
      req_pc_d   = req_pc_q;
      req_pred_d = req_pred_q;
      f_pc_d     = f_pc_q;
      f_inst_d   = f_inst_q;
      f_pred_d   = f_pred_q;
      unique case (state_q)
         FS_REQ: begin
            if (gnt_fire) begin
               req_pc_d   = pc_q;
               req_pred_d = bp_taken;
               // accepted request must still be drained if flushed
               state_d    = redirect ? FS_DROP : FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (redirect) begin
               state_d = im_rvalid ? FS_REQ : FS_DROP;
            end else if (im_rvalid) begin
               f_inst_d = im_rdata;
               f_pc_d   = req_pc_q;
               f_pred_d = req_pred_q;
               state_d  = FS_VALID;
            end
         end
         FS_VALID: begin
            if (redirect) begin
               f_inst_d = BUBBLE_INST;
               f_pc_d   = 32'd0;
               f_pred_d = 1'b0;
               state_d  = FS_REQ;
            end else if (!stall && !DM_stall) begin
               state_d = FS_REQ;
            end
         end
         FS_DROP: begin
            if (im_rvalid) begin
               state_d = FS_REQ;
            end
         end
         default: state_d = FS_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FS_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= 32'd0;
         req_pred_q <= 1'b0;
         f_pc_q     <= 32'd0;
         f_inst_q   <= BUBBLE_INST;
         f_pred_q   <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         req_pred_q <= req_pred_d;
         f_pc_q     <= f_pc_d;
         f_inst_q   <= f_inst_d;
         f_pred_q   <= f_pred_d;
         run_q      <= 1'b1;
      end
   end

endmodule
